// File: rtl/mem_dump_engine.sv
// Hex/ASCII memory dump engine: fetches one row into a buffer,
// then streams "\naddr: hh hh ...  ascii" over a valid/ready byte channel.
module mem_dump_engine #(
    parameter int AW  = 16,
    parameter int ROW = 16,
    parameter int GRP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    input  logic [1:0]    mode,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_a,
    output logic          mem_re,
    input  logic [7:0]    mem_vi,
    output logic [7:0]    ch_o,
    output logic          ch_v,
    input  logic          ch_rdy
);

    localparam int ND  = AW / 4;
    localparam int RW  = $clog2(ROW);
    localparam int AIW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [3:0] {
        IDLE, FETCH, WAITD, NL, ADDR, COLON, SPC,
        HEXHI, HEXLO, GAP, ASC, NEXT, TAIL, DONE
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   r;
    logic [AW:0]     rows;
    logic [RW-1:0]   idx;
    logic [AIW-1:0]  aidx;
    logic            gap;
    logic [1:0]      mode_q;
    logic            abort_q;
    logic            cap_v;
    logic [RW-1:0]   cap_i;
    logic [7:0]      rowbuf [ROW];

    logic            xfer, stop, last, grp_end;
    logic            hex_only, asc_only;
    logic [7:0]      cur;
    logic [AW-1:0]   rsh;
    logic [AW:0]     rows_calc;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        hexc = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign xfer     = ch_v && ch_rdy;
    assign stop     = abort || abort_q;
    assign last     = (idx == RW'(ROW - 1));
    assign grp_end  = ((int'(idx) + 1) % GRP) == 0;
    assign hex_only = (mode_q == 2'd0);
    assign asc_only = (mode_q == 2'd2);
    assign cur      = rowbuf[idx];
    assign rsh      = r >> (4 * (ND - 1 - int'(aidx)));

    // Row count includes the offset of base inside its first row.
    assign rows_calc = ({1'b0, base & AW'(ROW - 1)} + {1'b0, len}
                        + (AW + 1)'(ROW - 1)) >> RW;

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign mem_re = (state == FETCH);
    assign mem_a  = (state == FETCH) ? (r + AW'(idx)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = (len == '0) ? TAIL : FETCH;
            FETCH: if (stop) state_n = TAIL;
                   else if (last) state_n = WAITD;
            WAITD: state_n = stop ? TAIL : NL;
            NL:    if (xfer) state_n = stop ? TAIL : ADDR;
            ADDR:  if (xfer) state_n = stop ? TAIL :
                       (aidx == AIW'(ND - 1)) ? COLON : ADDR;
            COLON: if (xfer) state_n = stop ? TAIL :
                       asc_only ? GAP : SPC;
            SPC:   if (xfer) state_n = stop ? TAIL : HEXHI;
            HEXHI: if (xfer) state_n = stop ? TAIL : HEXLO;
            HEXLO: if (xfer) begin
                       if (stop)          state_n = TAIL;
                       else if (last)     state_n = hex_only ? NEXT : GAP;
                       else if (grp_end)  state_n = SPC;
                       else               state_n = HEXHI;
                   end
            GAP:   if (xfer) state_n = stop ? TAIL :
                       (asc_only || gap) ? ASC : GAP;
            ASC:   if (xfer) state_n = stop ? TAIL :
                       last ? NEXT : ASC;
            NEXT:  state_n = (stop || rows == (AW + 1)'(1)) ? TAIL : FETCH;
            TAIL:  if (xfer) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ch_v = 1'b1;
        ch_o = 8'h0a;
        unique case (state)
            NL, TAIL: ch_o = 8'h0a;
            ADDR:     ch_o = hexc(rsh[3:0]);
            COLON:    ch_o = 8'h3a;
            SPC, GAP: ch_o = 8'h20;
            HEXHI:    ch_o = hexc(cur[7:4]);
            HEXLO:    ch_o = hexc(cur[3:0]);
            ASC:      ch_o = (cur < 8'h20 || cur >= 8'h7f) ? 8'h2e : cur;
            default: begin
                ch_v = 1'b0;
                ch_o = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r       <= '0;
            rows    <= '0;
            idx     <= '0;
            aidx    <= '0;
            gap     <= 1'b0;
            mode_q  <= 2'd0;
            abort_q <= 1'b0;
            cap_v   <= 1'b0;
            cap_i   <= '0;
        end else begin
            cap_v <= mem_re;
            cap_i <= idx;
            if (state == IDLE) abort_q <= 1'b0;
            else if (abort)    abort_q <= 1'b1;
            if (state == IDLE && start) begin
                mode_q <= mode;
                r      <= base & ~AW'(ROW - 1);
                rows   <= rows_calc;
                idx    <= '0;
                aidx   <= '0;
                gap    <= 1'b0;
            end
            // idx wraps to zero after each full pass over the row.
            if (state == FETCH ||
                (xfer && (state == HEXLO || state == ASC)))
                idx <= idx + 1'b1;
            if (xfer && state == ADDR)
                aidx <= (aidx == AIW'(ND - 1)) ? '0 : aidx + 1'b1;
            if (xfer && state == GAP)
                gap <= !gap && !asc_only;
            if (state == NEXT) begin
                r    <= r + AW'(ROW);
                rows <= rows - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_v) rowbuf[cap_i] <= mem_vi;
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine: a string-level reference model
// feeds an expected-character queue that a monitor drains.
module tb_mem_dump_engine;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ch_rdy = 1'b1;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, mem_re, ch_v;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_vi;
    logic [7:0]    ch_o;

    logic [7:0] mem [65536];
    logic [7:0] exp_q [$];
    logic [7:0] cap_q [$];

    int  tests = 0;
    int  fails = 0;
    int  n_out = 0;
    int  n_re = 0;
    int  n_re_post = 0;
    int  n_done = 0;
    bit  capture = 1'b0;
    bit  abort_armed = 1'b0;
    bit  rnd_rdy = 1'b0;

    mem_dump_engine #(.AW(16), .ROW(16), .GRP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .mode(mode), .abort(abort), .busy(busy), .done(done),
        .mem_a(mem_a), .mem_re(mem_re), .mem_vi(mem_vi),
        .ch_o(ch_o), .ch_v(ch_v), .ch_rdy(ch_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_vi <= mem[mem_a];

    initial begin
        int stall = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rnd_rdy) ch_rdy = 1'b1;
            else if (stall > 0) begin
                ch_rdy = 1'b0;
                stall--;
            end else if ($urandom_range(0, 15) == 0) begin
                ch_rdy = 1'b0;
                stall = 19;
            end else ch_rdy = $urandom_range(0, 1) == 1;
        end
    end

    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] stall_ch = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) stall_prev = 1'b0;
            else begin
                if (mem_re) n_re++;
                if (mem_re && abort_armed) n_re_post++;
                if (done) n_done++;
                if (stall_prev) begin
                    tests++;
                    if (!ch_v || ch_o !== stall_ch) begin
                        fails++;
                        $display("FAIL hold: ch_v=%0b ch_o=%02h, need 1/%02h",
                                 ch_v, ch_o, stall_ch);
                    end
                end
                stall_prev = ch_v && !ch_rdy;
                stall_ch = ch_o;
                if (ch_v && ch_rdy) begin
                    n_out++;
                    if (capture) cap_q.push_back(ch_o);
                    else if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra char: got %02h, none expected", ch_o);
                    end else begin
                        e = exp_q.pop_front();
                        tests++;
                        if (ch_o !== e) begin
                            fails++;
                            $display("FAIL char %0d: got %02h expected %02h",
                                     n_out, ch_o, e);
                        end
                    end
                end
            end
        end
    end

    function automatic string model(input int b, input int l, input int m);
        string s = "";
        int a0, nrows, r;
        logic [7:0] c;
        a0 = b - (b % 16);
        nrows = (l == 0) ? 0 : (b - a0 + l + 15) / 16;
        for (int k = 0; k < nrows; k++) begin
            r = (a0 + 16 * k) % 65536;
            s = {s, $sformatf("\n%04x:", r)};
            if (m != 2)
                for (int i = 0; i < 16; i++) begin
                    if (i % 4 == 0) s = {s, " "};
                    s = {s, $sformatf("%02x", mem[(r + i) % 65536])};
                end
            if (m == 2) s = {s, " "};
            else if (m != 0) s = {s, "  "};
            if (m != 0)
                for (int i = 0; i < 16; i++) begin
                    c = mem[(r + i) % 65536];
                    if (c < 8'h20 || c >= 8'h7f) c = 8'h2e;
                    s = {s, $sformatf("%c", c)};
                end
        end
        return {s, "\n"};
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    endtask

    task automatic check_eq(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        n_out = 0;
        n_re = 0;
        n_re_post = 0;
        n_done = 0;
        abort_armed = 1'b0;
    endtask

    task automatic do_start(input int b, input int l, input int m);
        @(posedge clk);
        #1;
        base = AW'(b);
        len = AW'(l);
        mode = 2'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (n_out < n && c < 5000) begin
            @(posedge clk);
            c++;
        end
        check_eq("progress", int'(n_out >= n), 1);
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (n_done == 0 && c < 20000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq({nm, " done"}, n_done, 1);
        check_eq({nm, " leftover"}, exp_q.size(), 0);
        check_eq({nm, " busy"}, int'(busy), 0);
    endtask

    task automatic run_model(input string nm, input int b, input int l,
                             input int m, input int nre);
        clr();
        push_str(model(b, l, m));
        do_start(b, l, m);
        wait_done(nm);
        check_eq({nm, " mem_re"}, n_re, nre);
    endtask

    localparam string HELLO =
        "\n1000: 48656c6c 6f2c2065 4a333221 0a00017f  Hello, eJ32!....\n";

    initial begin
        string full;
        int k, mism;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            full = "Hello, eJ32!\n";
            mem[16'h1000 + i] = (i < 13) ? 8'(full[i]) : 8'h00;
        end
        mem[16'h100e] = 8'h01;
        mem[16'h100f] = 8'h7f;

        #3;
        check_eq("reset outputs",
                 int'({busy, done, mem_re, ch_v, mem_a, ch_o} != '0), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        clr();
        push_str(HELLO);
        do_start(16'h1000, 16'h10, 1);
        wait_done("hello");
        check_eq("hello chars", n_out, 61);
        check_eq("hello mem_re", n_re, 16);

        run_model("offset", 16'h1003, 16'h10, 0, 32);
        check_eq("offset chars", n_out, 85);

        run_model("len0", 16'h1003, 0, 1, 0);
        check_eq("len0 chars", n_out, 1);

        rnd_rdy = 1'b1;
        clr();
        push_str(HELLO);
        do_start(16'h1000, 16'h10, 1);
        wait_done("hello bp");
        check_eq("hello bp chars", n_out, 61);
        rnd_rdy = 1'b0;

        clr();
        capture = 1'b1;
        cap_q.delete();
        full = model(16'h2000, 16'h40, 0);
        do_start(16'h2000, 16'h40, 0);
        wait_out(10);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        abort_armed = 1'b1;
        wait_done("abort");
        capture = 1'b0;
        k = cap_q.size();
        check_eq("abort in row1 hex", int'(k >= 11 && k <= 43), 1);
        check_eq("abort tail nl", int'(k > 0 && cap_q[k - 1] == 8'h0a), 1);
        mism = 0;
        for (int i = 0; i < k - 1 && i < full.len(); i++)
            if (cap_q[i] != 8'(full[i])) mism++;
        check_eq("abort prefix", mism, 0);
        check_eq("abort mem_re after", n_re_post, 0);

        clr();
        push_str(model(16'hfff0, 16'h20, 1));
        do_start(16'hfff0, 16'h20, 1);
        repeat (20) @(posedge clk);
        do_start(16'h1000, 16'h10, 0);
        wait_done("wrap");
        check_eq("wrap mem_re", n_re, 32);

        clr();
        capture = 1'b1;
        do_start(16'h1000, 16'h30, 1);
        wait_out(20);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("async reset", int'({busy, ch_v, mem_re} != 3'b000), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        capture = 1'b0;
        cap_q.delete();
        repeat (3) @(posedge clk);
        check_eq("reset no done", n_done, 0);
        run_model("after reset", 16'h1000, 16'h10, 1, 16);

        for (int t = 0; t < 6; t++) begin
            int b, l, m;
            b = $urandom_range(0, 65535);
            l = $urandom_range(1, 16'h48);
            m = $urandom_range(0, 3);
            rnd_rdy = $urandom_range(0, 1) == 1;
            run_model($sformatf("rand%0d", t), b, l, m,
                      16 * ((b % 16 + l + 15) / 16));
        end
        rnd_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
